// File: rtl/incond_pkg.sv
// Shared defaults and helpers for the keypad/switch input conditioner.
package incond_pkg;
  localparam int DEF_ROWS       = 5;
  localparam int DEF_COLS       = 5;
  localparam int DEF_NSW        = 16;
  localparam int DEF_DWELL_BITS = 8;
  localparam int DEF_KEY_DB     = 4;
  localparam int DEF_SW_DB_BITS = 16;
  localparam int DEF_REP_DELAY  = 32;
  localparam int DEF_REP_RATE   = 8;

  // Width needed to encode n distinct values, never less than one bit.
  function automatic int code_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/input_conditioner_db_cell.sv
// Counter debouncer: the state flips after THRESH consecutive enabled samples that differ from it.
module db_cell #(
  parameter int THRESH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_din,
  output logic o_state
);
  localparam int CW = $clog2(THRESH + 1);

  logic [CW-1:0] r_cnt;
  logic          r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_state <= 1'b0;
    end else if (i_en) begin
      if (i_din == r_state) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(THRESH - 1)) begin
        r_cnt   <= '0;
        r_state <= i_din;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_state = r_state;
endmodule

// File: rtl/input_conditioner.sv
// Keypad column scanner, key/switch debouncing and a one-deep press-event register.
// Define INCOND_REPEAT_EN to add auto-repeat of the most recently pressed key.
module input_conditioner
  import incond_pkg::*;
#(
  parameter  int ROWS       = DEF_ROWS,
  parameter  int COLS       = DEF_COLS,
  parameter  int NSW        = DEF_NSW,
  parameter  int DWELL_BITS = DEF_DWELL_BITS,
  parameter  int KEY_DB     = DEF_KEY_DB,
  parameter  int SW_DB_BITS = DEF_SW_DB_BITS,
  parameter  int REP_DELAY  = DEF_REP_DELAY,
  parameter  int REP_RATE   = DEF_REP_RATE,
  localparam int NKEY       = ROWS * COLS,
  localparam int CODE_W     = code_w(ROWS * COLS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSW-1:0]    sw_in,
  output logic [COLS-1:0]   key_col,
  input  logic [ROWS-1:0]   key_row,
  output logic [NSW-1:0]    sw_ok,
  output logic [NKEY-1:0]   key_ok,
  output logic              evt_valid,
  output logic [CODE_W-1:0] evt_code,
  input  logic              evt_ready,
  output logic              evt_drop
);
  localparam int COL_W = code_w(COLS);

  logic [COL_W-1:0]      r_col;
  logic [DWELL_BITS-1:0] r_dwell;
  logic                  w_sample;

  assign w_sample = &r_dwell;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col   <= '0;
      r_dwell <= '0;
    end else begin
      r_dwell <= r_dwell + 1'b1;
      if (w_sample) r_col <= (r_col == COL_W'(COLS - 1)) ? '0 : r_col + 1'b1;
    end
  end

  always_comb begin
    for (int c = 0; c < COLS; c++) key_col[c] = (r_col != COL_W'(c));
  end

  // Rows only settle late in the dwell, so each key is sampled on the last dwell cycle of its column.
  for (genvar k = 0; k < NKEY; k++) begin : g_key
    db_cell #(.THRESH(KEY_DB)) u_db (
      .clk     (clk),
      .rst     (rst),
      .i_en    (w_sample && (r_col == COL_W'(k % COLS))),
      .i_din   (~key_row[k / COLS]),
      .o_state (key_ok[k])
    );
  end

  for (genvar s = 0; s < NSW; s++) begin : g_sw
    db_cell #(.THRESH(1 << SW_DB_BITS)) u_db (
      .clk     (clk),
      .rst     (rst),
      .i_en    (1'b1),
      .i_din   (sw_in[s]),
      .o_state (sw_ok[s])
    );
  end

  function automatic logic [CODE_W-1:0] f_lowest(input logic [NKEY-1:0] v);
    f_lowest = '0;
    for (int k = NKEY - 1; k >= 0; k--) if (v[k]) f_lowest = CODE_W'(k);
  endfunction

  logic [NKEY-1:0] r_key_prev;
  logic [NKEY-1:0] w_rise;
  logic [NKEY-1:0] w_req;

  assign w_rise = key_ok & ~r_key_prev;

`ifdef INCOND_REPEAT_EN
  logic              r_rep_act;
  logic              r_rep_first;
  logic [CODE_W-1:0] r_rep_code;
  logic [15:0]       r_rep_cnt;
  logic [15:0]       w_rep_lim;
  logic              w_frame_end;
  logic              w_rep_fire;

  assign w_frame_end = w_sample && (r_col == COL_W'(COLS - 1));
  assign w_rep_lim   = r_rep_first ? 16'(REP_DELAY - 1) : 16'(REP_RATE - 1);
  assign w_rep_fire  = r_rep_act && key_ok[r_rep_code] && w_frame_end && (r_rep_cnt == w_rep_lim);
  assign w_req       = w_rise | (w_rep_fire ? (NKEY'(1) << r_rep_code) : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rep_act   <= 1'b0;
      r_rep_first <= 1'b0;
      r_rep_code  <= '0;
      r_rep_cnt   <= '0;
    end else if (|w_rise) begin
      r_rep_act   <= 1'b1;
      r_rep_first <= 1'b1;
      r_rep_code  <= f_lowest(w_rise);
      r_rep_cnt   <= '0;
    end else if (r_rep_act && !key_ok[r_rep_code]) begin
      r_rep_act <= 1'b0;
    end else if (r_rep_act && w_frame_end) begin
      if (r_rep_cnt == w_rep_lim) begin
        r_rep_cnt   <= '0;
        r_rep_first <= 1'b0;
      end else begin
        r_rep_cnt <= r_rep_cnt + 1'b1;
      end
    end
  end
`else
  logic w_unused_rep;
  assign w_unused_rep = (REP_DELAY + REP_RATE) != 0;
  assign w_req        = w_rise;
`endif

  logic              r_valid;
  logic [CODE_W-1:0] r_code;
  logic              r_drop;
  logic              w_any;
  logic              w_multi;
  logic              w_can_load;

  assign w_any      = |w_req;
  assign w_multi    = |(w_req & (w_req - NKEY'(1)));
  assign w_can_load = !r_valid || evt_ready;

  // Several requests in one cycle collapse into a single drop pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key_prev <= '0;
      r_valid    <= 1'b0;
      r_code     <= '0;
      r_drop     <= 1'b0;
    end else begin
      r_key_prev <= key_ok;
      r_drop     <= w_any && (!w_can_load || w_multi);
      if (w_any && w_can_load) begin
        r_valid <= 1'b1;
        r_code  <= f_lowest(w_req);
      end else if (evt_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign evt_valid = r_valid;
  assign evt_code  = r_code;
  assign evt_drop  = r_drop;
endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter ROWS, default 5: keypad row count.
REQ-002 Parameter COLS, default 5: keypad column count; key index k = row*COLS + col; NKEY = ROWS*COLS.
REQ-003 Parameter NSW, default 16: slide-switch count.
REQ-004 Parameter DWELL_BITS, default 8: each column is driven for 2^DWELL_BITS cycles.
REQ-005 Parameter KEY_DB, default 4: consecutive equal frame samples required to change a key state.
REQ-006 Parameter SW_DB_BITS, default 16: a switch changes state after 2^SW_DB_BITS consecutive differing cycles.
REQ-007 clk  input  1  sole clock, rising edge.
REQ-008 rst  input  1  asynchronous, active-high reset.
REQ-009 sw_in  input  NSW  raw switch levels.
REQ-010 key_col  output  COLS  column drive, active-low, one-cold.
REQ-011 key_row  input  ROWS  row sense, active-low (0 = pressed).
REQ-012 sw_ok  output  NSW  debounced switch levels.
REQ-013 key_ok  output  NKEY  debounced key states (1 = pressed).
REQ-014 evt_valid  output  1  key event available.
REQ-015 evt_code  output  clog2(NKEY)  key index of the event.
REQ-016 evt_ready  input  1  consumer accepts event.
REQ-017 evt_drop  output  1  one-cycle pulse: an event was lost.

Function
REQ-018 The column counter SHALL advance 0..COLS-1 and wrap to 0, driving key_col[c]=0 and all other bits 1.
REQ-019 Rows SHALL be sampled only on the last dwell cycle of each column; a frame is COLS*2^DWELL_BITS cycles.
REQ-020 Each key SHALL have a frame-rate counter: a sample differing from key_ok[k] increments it, an equal sample clears it, and reaching KEY_DB toggles key_ok[k] and clears the counter.
REQ-021 Each switch SHALL follow the same rule at clock rate with threshold 2^SW_DB_BITS; sw_ok changes exactly on the cycle the count reaches the threshold.
REQ-022 A 0->1 transition of key_ok[k] SHALL be a press event; releases SHALL NOT generate events.
REQ-023 The event register SHALL load on a press when empty or when being accepted in that cycle (evt_valid && evt_ready).
REQ-024 A handshake completes when evt_valid && evt_ready; evt_code SHALL stay stable while evt_valid && !evt_ready.
REQ-025 A press arriving while the register is full and not being accepted SHALL be discarded and SHALL pulse evt_drop.
REQ-026 Simultaneous presses can only occur within one column sample; the lowest key index SHALL be loaded and each other press SHALL pulse evt_drop once, as a single pulse for that cycle.
REQ-027 Event latency: evt_valid SHALL assert one cycle after the key_ok transition.

Reset
REQ-028 On rst: column counter = 0 (key_col = all ones except bit 0 low); dwell counter, all debounce counters, sw_ok, key_ok, evt_valid, evt_code, evt_drop = 0; repeat state cleared.
REQ-029 Reset asserted mid-frame or mid-handshake SHALL discard the pending event without an evt_drop pulse.

Configuration
REQ-030 With INCOND_REPEAT_EN defined: a key held for REP_DELAY frames (parameter, default 32) after its press SHALL generate a repeat event with the same code, then one every REP_RATE frames (default 8) while held, using the normal event and drop rules; only the most recently pressed key repeats.
REQ-031 Without INCOND_REPEAT_EN: no repeat logic; only press events; REP_* parameters are ignored.

Structure
REQ-032 Package incond_pkg SHALL hold the default parameter constants and a function computing the code width, clog2(NKEY), minimum 1.
REQ-033 A sub-module db_cell (a parametrised-threshold counter debouncer with an enable input) SHALL be instantiated once per key (enable = column sample strobe) and once per switch (enable = 1).

Verification
REQ-034 Use ROWS=COLS=2, DWELL_BITS=2, KEY_DB=2, SW_DB_BITS=2.
REQ-035 Hold key_row[1]=0 while col 0 is driven for 2 frames -> key_ok[2]=1; evt_valid=1, evt_code=2 one cycle later.
REQ-036 Toggle sw_in[0] for 3 cycles, then hold it for 4 cycles -> sw_ok[0] stays 0 while toggling, then rises on the 4th held cycle.
REQ-037 Press keys 0 and 2 together with evt_ready=0 -> evt_code=0, evt_drop pulses once; a later press of key 3 before ready -> another evt_drop pulse and evt_code stays 0.
REQ-038 With evt_valid=1, assert evt_ready together with a new press of key 1 -> handshake completes and evt_code=1 the next cycle, with no drop.
REQ-039 Assert rst mid-dwell with evt_valid=1 -> all outputs 0 and key_col=2'b10 immediately; no evt_drop.
REQ-040 With INCOND_REPEAT_EN defined, REP_DELAY=2, REP_RATE=1, evt_ready=1, and key 3 held -> events at the press, after 2 frames, then every frame.
